// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// UART transmitter with a configurable frame and a small byte FIFO in front.
// The frame has a configurable data width, optional odd/even parity, one or two
// stop bits and an integer baud divisor. Frames stream back to back with no idle
// gap while the FIFO holds data. A one-cycle pulse marks the end of each frame.

module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        sourceClk,
    input  logic                        reset,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_byte,
    output logic                        tx_out,
    output logic                        tx_busy,
    output logic                        tx_complete,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST  = 1'(STOP_BITS - 1);

    // Reject parameter combinations the datapath cannot represent.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx_fifo: DATA_BITS must be in 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    // Transmitter state
    state_t               state;
    state_t               state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_next;
    logic                 stop_idx;
    logic                 stop_next;
    logic [DATA_BITS-1:0] shifter;
    logic [DATA_BITS-1:0] shift_next;
    logic                 parity_bit;
    logic                 parity_next;
    logic                 line_bit;
    logic                 line_next;
    logic                 bit_end;

    // tx_ready depends only on the registered count, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign tx_ready   = (count != COUNT_FULL);
    assign push       = tx_valid & tx_ready;
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // Parity is taken over the word as it leaves the FIFO; odd parity inverts the XOR.
    assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign tx_out      = line_bit;
    assign tx_busy     = (state != IDLE) || (count != '0);
    assign tx_complete = (state == STOP) && bit_end && (stop_idx == STOP_LAST);

    // Storage array: written on an accepted push, never reset because the
    // pointers and count define which entries are meaningful.
    always_ff @(posedge sourceClk) begin
        if (push) begin
            mem[wr_ptr] <= tx_byte;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count distinguishes full from empty.
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmitter registers; reset drives the line high at once and abandons any frame.
    always_ff @(posedge sourceClk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shifter    <= '0;
            parity_bit <= 1'b0;
            line_bit   <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            stop_idx   <= stop_next;
            shifter    <= shift_next;
            parity_bit <= parity_next;
            line_bit   <= line_next;
        end
    end

    // Next-state logic: each bit lasts one full baud period, and the line value for
    // the next bit is registered on the edge that ends the current one.
    always_comb begin
        state_next  = state;
        baud_next   = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        bit_next    = bit_idx;
        stop_next   = stop_idx;
        shift_next  = shifter;
        parity_next = parity_bit;
        line_next   = line_bit;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                baud_next = '0;
                line_next = 1'b1;
                if (count != '0) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    parity_next = head_parity;
                    line_next   = 1'b0;
                    state_next  = START;
                end
            end

            START: begin
                if (bit_end) begin
                    line_next  = shifter[0];
                    shift_next = shifter >> 1;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_idx == DATA_LAST) begin
                        if (PARITY != 0) begin
                            line_next  = parity_bit;
                            state_next = PARITY_BIT;
                        end else begin
                            line_next  = 1'b1;
                            stop_next  = 1'b0;
                            state_next = STOP;
                        end
                    end else begin
                        line_next  = shifter[0];
                        shift_next = shifter >> 1;
                        bit_next   = bit_idx + IDX_W'(1);
                    end
                end
            end

            PARITY_BIT: begin
                if (bit_end) begin
                    line_next  = 1'b1;
                    stop_next  = 1'b0;
                    state_next = STOP;
                end
            end

            STOP: begin
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        if (count != '0) begin
                            pop         = 1'b1;
                            shift_next  = head;
                            parity_next = head_parity;
                            line_next   = 1'b0;
                            state_next  = START;
                        end else begin
                            line_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end
            end

            default: begin
                line_next  = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Drives three differently configured transmitters from one stimulus stream and
// compares every output, every cycle, against a frame-timing model: each accepted
// word gets a start cycle max(push+1, previous start + frame length), and the line
// value is looked up from the word's bit pattern.

module tb_uart_tx_fifo;

    localparam int NINST  = 3;
    localparam int MAXFR  = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_byte;

    logic [NINST-1:0] ready_w;
    logic [NINST-1:0] out_w;
    logic [NINST-1:0] busy_w;
    logic [NINST-1:0] comp_w;
    logic [2:0]       cnt_a;
    logic [2:0]       cnt_b;
    logic [1:0]       cnt_c;

    // Per-instance configuration as seen by the model
    int cfg_db  [NINST] = '{8, 5, 7};
    int cfg_par [NINST] = '{2, 0, 1};
    int cfg_sb  [NINST] = '{1, 2, 1};
    int cfg_cpb [NINST] = '{4, 4, 2};
    int cfg_dep [NINST] = '{4, 4, 2};

    // Model: push edge, start edge and data of every accepted word since the last reset
    int fp [NINST][MAXFR];
    int fs [NINST][MAXFR];
    int fd [NINST][MAXFR];
    int nf [NINST];

    int t;
    int tests;
    int fails;
    int comp_seen;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
        .sourceClk(clk), .reset(rst_n), .tx_valid(tx_valid), .tx_ready(ready_w[0]),
        .tx_byte(tx_byte), .tx_out(out_w[0]), .tx_busy(busy_w[0]),
        .tx_complete(comp_w[0]), .fifo_count(cnt_a)
    );

    uart_tx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_b (
        .sourceClk(clk), .reset(rst_n), .tx_valid(tx_valid), .tx_ready(ready_w[1]),
        .tx_byte(tx_byte[4:0]), .tx_out(out_w[1]), .tx_busy(busy_w[1]),
        .tx_complete(comp_w[1]), .fifo_count(cnt_b)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(2), .FIFO_DEPTH(2)) dut_c (
        .sourceClk(clk), .reset(rst_n), .tx_valid(tx_valid), .tx_ready(ready_w[2]),
        .tx_byte(tx_byte[6:0]), .tx_out(out_w[2]), .tx_busy(busy_w[2]),
        .tx_complete(comp_w[2]), .fifo_count(cnt_c)
    );

    function automatic int frameLen(int i);
        return (1 + cfg_db[i] + ((cfg_par[i] != 0) ? 1 : 0) + cfg_sb[i]) * cfg_cpb[i];
    endfunction

    // Bit number idx of the frame for word d: start, data LSb first, parity, stops.
    function automatic int frameBit(int i, int d, int idx);
        int ones;
        if (idx == 0) return 0;
        if (idx <= cfg_db[i]) return (d >> (idx - 1)) & 1;
        if (cfg_par[i] != 0 && idx == cfg_db[i] + 1) begin
            ones = 0;
            for (int j = 0; j < cfg_db[i]; j++) ones += (d >> j) & 1;
            return (cfg_par[i] == 2) ? (ones % 2) : (1 - (ones % 2));
        end
        return 1;
    endfunction

    function automatic int expLine(int i, int tt);
        for (int k = 0; k < nf[i]; k++)
            if (tt >= fs[i][k] && tt < fs[i][k] + frameLen(i))
                return frameBit(i, fd[i][k], (tt - fs[i][k]) / cfg_cpb[i]);
        return 1;
    endfunction

    function automatic int expComplete(int i, int tt);
        for (int k = 0; k < nf[i]; k++)
            if (tt == fs[i][k] + frameLen(i) - 1) return 1;
        return 0;
    endfunction

    function automatic int expCount(int i, int tt);
        int c = 0;
        for (int k = 0; k < nf[i]; k++) begin
            if (fp[i][k] <= tt) c++;
            if (fs[i][k] <= tt) c--;
        end
        return c;
    endfunction

    function automatic int expBusy(int i, int tt);
        if (expCount(i, tt) != 0) return 1;
        for (int k = 0; k < nf[i]; k++)
            if (tt >= fs[i][k] && tt < fs[i][k] + frameLen(i)) return 1;
        return 0;
    endfunction

    task automatic checkOne(input string tag, input int i, input logic [7:0] obs, input int expv);
        tests++;
        assert (obs === 8'(expv))
        else begin
            fails++;
            $error("[TB] FAIL %s dut%0d t=%0d observed=%0d expected=%0d", tag, i, t, obs, expv);
        end
    endtask

    task automatic checkOutput();
        logic [7:0] cnt;
        for (int i = 0; i < NINST; i++) begin
            cnt = (i == 0) ? 8'(cnt_a) : (i == 1) ? 8'(cnt_b) : 8'(cnt_c);
            checkOne("tx_out",      i, 8'(out_w[i]),   expLine(i, t));
            checkOne("tx_complete", i, 8'(comp_w[i]),  expComplete(i, t));
            checkOne("tx_busy",     i, 8'(busy_w[i]),  expBusy(i, t));
            checkOne("tx_ready",    i, 8'(ready_w[i]), (expCount(i, t) != cfg_dep[i]) ? 1 : 0);
            checkOne("fifo_count",  i, cnt,            expCount(i, t));
        end
    endtask

    // One clock cycle: drive inputs, let the model decide acceptance from its own
    // count, advance past the edge, then check all outputs at the falling edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, output logic acc_a);
        logic [NINST-1:0] acc;
        int s;
        tx_valid = valid;
        tx_byte  = data;
        for (int i = 0; i < NINST; i++)
            acc[i] = valid && rst_n && (expCount(i, t) != cfg_dep[i]) && (nf[i] < MAXFR);
        @(posedge clk);
        t++;
        for (int i = 0; i < NINST; i++) begin
            if (acc[i]) begin
                s = t + 1;
                if (nf[i] > 0 && fs[i][nf[i]-1] + frameLen(i) > s) s = fs[i][nf[i]-1] + frameLen(i);
                fp[i][nf[i]] = t;
                fs[i][nf[i]] = s;
                fd[i][nf[i]] = int'(data) & ((1 << cfg_db[i]) - 1);
                nf[i]++;
            end
        end
        acc_a = acc[0];
        @(negedge clk);
        tx_valid = 1'b0;
        comp_seen += int'(comp_w[0]);
        checkOutput();
    endtask

    task automatic runIdle(input int n);
        logic dummy;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00, dummy);
    endtask

    initial begin
        logic       acc;
        int         n_acc;
        int         guard;
        logic [7:0] word;

        tests     = 0;
        fails     = 0;
        comp_seen = 0;
        t         = 0;
        for (int i = 0; i < NINST; i++) nf[i] = 0;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;

        // Reset state
        @(negedge clk);
        checkOutput();
        runIdle(2);
        rst_n = 1'b1;
        runIdle(3);

        // Single 0xA5 frame: even parity on dut_a gives 0,1,0,1,0,0,1,0,1,0,1
        comp_seen = 0;
        applyStimulus(1'b1, 8'hA5, acc);
        runIdle(50);
        checkOne("t1_completes", 0, 8'(comp_seen), 1);

        // Parity corner words: 0x01 odd on dut_c, 0x07 even on dut_a
        applyStimulus(1'b1, 8'h01, acc);
        runIdle(50);
        applyStimulus(1'b1, 8'h07, acc);
        runIdle(50);

        // Back-to-back words until six accepted by dut_a; extras while full are dropped
        comp_seen = 0;
        n_acc     = 0;
        guard     = 0;
        word      = 8'h30;
        while (n_acc < 6 && guard < 400) begin
            applyStimulus(1'b1, word, acc);
            if (acc) begin
                n_acc++;
                word = word + 8'h11;
            end
            guard++;
        end
        runIdle(6 * 44 + 20);
        checkOne("t3_completes", 0, 8'(comp_seen), 6);

        // T4 word on the five-bit, two-stop instance
        applyStimulus(1'b1, 8'h1F, acc);
        runIdle(50);

        // Reset in the middle of a data bit with three words still queued in dut_a
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'hC3 + k), acc);
        runIdle(8);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NINST; i++) nf[i] = 0;
        #1;
        checkOutput();
        @(negedge clk);
        runIdle(2);
        rst_n = 1'b1;
        runIdle(60);

        // Random traffic, then drain
        for (int k = 0; k < 600; k++)
            applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)), acc);
        runIdle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
